// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N-channel button debouncer with press, release and hold/repeat pulses
module multi_debouncer #(
    parameter int NUM_CH        = 4,
    parameter int DEBOUNCE_WAIT = 8,
    parameter int HOLD_CYCLES   = 1000000,
    parameter int REPEAT_CYCLES = 0,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press_pls,
    output logic [NUM_CH-1:0] release_pls,
    output logic [NUM_CH-1:0] hold_pls
);

    localparam int DW   = $clog2(DEBOUNCE_WAIT + 1);
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_WAIT - 1);
    localparam logic [HW-1:0] HOLD_VAL  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] REP_VAL   = HW'(REPEAT_CYCLES);
    localparam logic [HW-1:0] HCNT_ONE  = HW'(1);
    localparam logic          INV       = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_REPEAT,
        ST_DONE
    } hold_state_e;

    logic [NUM_CH-1:0] s1_q;
    logic [NUM_CH-1:0] s2_q;

    // Inverting ahead of the synchroniser keeps "1 = pressed" everywhere downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn ^ {NUM_CH{INV}};
            s2_q <= s1_q;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [DW-1:0] dcnt_q, dcnt_d;
        logic [HW-1:0] hcnt_q, hcnt_d;
        hold_state_e   state_q, state_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          hold_q, hold_d;
        logic          accept, rise, fall;

        assign accept = (s2_q[ch] != level_q) && (dcnt_q == DCNT_LAST);
        assign rise   = accept && s2_q[ch];
        assign fall   = accept && !s2_q[ch];

        always_ff @(posedge clk) begin
            if (rst) begin
                dcnt_q  <= '0;
                hcnt_q  <= '0;
                state_q <= ST_IDLE;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                hold_q  <= 1'b0;
            end else begin
                dcnt_q  <= dcnt_d;
                hcnt_q  <= hcnt_d;
                state_q <= state_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                hold_q  <= hold_d;
            end
        end

        always_comb begin
            dcnt_d  = dcnt_q;
            level_d = level_q;
            state_d = state_q;
            hcnt_d  = hcnt_q;
            if (s2_q[ch] == level_q) begin
                dcnt_d = '0;
            end else if (accept) begin
                dcnt_d  = '0;
                level_d = s2_q[ch];
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end

            if (fall) begin
                state_d = ST_IDLE;
                hcnt_d  = '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            state_d = ST_FIRST;
                            hcnt_d  = HCNT_ONE;
                        end
                    end
                    ST_FIRST: begin
                        if (hcnt_q == HOLD_VAL) begin
                            state_d = (REPEAT_CYCLES > 0) ? ST_REPEAT : ST_DONE;
                            hcnt_d  = (REPEAT_CYCLES > 0) ? HCNT_ONE : hcnt_q;
                        end else begin
                            hcnt_d = hcnt_q + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        hcnt_d = (hcnt_q == REP_VAL) ? HCNT_ONE : hcnt_q + 1'b1;
                    end
                    ST_DONE: begin
                        hcnt_d = hcnt_q;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        hcnt_d  = '0;
                    end
                endcase
            end
        end

        // A hold match on the release edge is dropped so hold never overlaps release.
        always_comb begin
            press_d = rise;
            rel_d   = fall;
            hold_d  = 1'b0;
            if (!fall) begin
                unique case (state_q)
                    ST_FIRST:  hold_d = (hcnt_q == HOLD_VAL);
                    ST_REPEAT: hold_d = (hcnt_q == REP_VAL);
                    default:   hold_d = 1'b0;
                endcase
            end
        end

        assign level[ch]       = level_q;
        assign press_pls[ch]   = press_q;
        assign release_pls[ch] = rel_q;
        assign hold_pls[ch]    = hold_q;
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - scoreboard bench for multi_debouncer
module tb_multi_debouncer;

    localparam int HOLD = 20;
    localparam int LAT  = 10;

    logic       clk;
    logic       rst;
    logic [1:0] btn_a, btn_c;
    logic [1:0] level_a, press_a, rel_a, hold_a;
    logic [1:0] level_b, press_b, rel_b, hold_b;
    logic [1:0] level_c, press_c, rel_c, hold_c;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] hd;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    ev_t qc[$];

    multi_debouncer #(.NUM_CH(2), .DEBOUNCE_WAIT(8), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(5), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst(rst), .btn(btn_a), .level(level_a),
        .press_pls(press_a), .release_pls(rel_a), .hold_pls(hold_a)
    );

    multi_debouncer #(.NUM_CH(2), .DEBOUNCE_WAIT(8), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(0), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst(rst), .btn(btn_a), .level(level_b),
        .press_pls(press_b), .release_pls(rel_b), .hold_pls(hold_b)
    );

    multi_debouncer #(.NUM_CH(2), .DEBOUNCE_WAIT(8), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(5), .ACTIVE_LOW(1)) dut_c (
        .clk(clk), .rst(rst), .btn(btn_c), .level(level_c),
        .press_pls(press_c), .release_pls(rel_c), .hold_pls(hold_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 3000) begin
            $display("FAIL watchdog: cycle %0d exceeds budget 3000", cyc);
            $fatal(1, "watchdog");
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int inst, input int c, input logic [1:0] pr, input logic [1:0] rl,
                        input logic [1:0] hd);
        ev_t e;
        e.cyc = c;
        e.pr  = pr;
        e.rl  = rl;
        e.hd  = hd;
        case (inst)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    // Press at p, holds every rep after the first while still held, release at rel.
    task automatic expect_train(input int inst, input logic [1:0] ch, input int p, input int rel,
                                input int rep);
        push(inst, p, ch, 2'b00, 2'b00);
        if (p + HOLD < rel) begin
            push(inst, p + HOLD, 2'b00, 2'b00, ch);
            if (rep > 0) begin
                for (int t = p + HOLD + rep; t < rel; t += rep) begin
                    push(inst, t, 2'b00, 2'b00, ch);
                end
            end
        end
        push(inst, rel, 2'b00, ch, 2'b00);
    endtask

    task automatic mon(input int inst, input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] hd);
        ev_t         e;
        logic [63:0] obs, exp;
        bit          have;
        string       tag;
        have = 1'b0;
        tag  = $sformatf("pulse_%0d", inst);
        obs  = {32'(cyc), 26'b0, pr, rl, hd};
        if ((pr | rl | hd) != 2'b00) begin
            case (inst)
                0:       if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
                1:       if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
                default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
            endcase
            exp = have ? {32'(e.cyc), 26'b0, e.pr, e.rl, e.hd} : 64'd0;
            check(tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        mon(0, press_a, rel_a, hold_a);
        mon(1, press_b, rel_b, hold_b);
        mon(2, press_c, rel_c, hold_c);
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int k;
    int p2;

    initial begin
        rst   = 1'b1;
        btn_a = 2'b00;
        btn_c = 2'b11;
        tick(3);
        check("rst_level_a", 64'(level_a), 64'd0);
        check("rst_level_c", 64'(level_c), 64'd0);
        check("rst_pulses_a", 64'({press_a, rel_a, hold_a}), 64'd0);
        rst = 1'b0;

        // Active-low channel: held-high raw input must not press after reset
        tick(15);
        check("al_no_press", 64'(level_c), 64'd0);
        k = cyc;
        btn_c[0] = 1'b0;
        expect_train(2, 2'b01, k + LAT, k + 25, 5);
        wait_cyc(k + LAT - 1);
        check("al_level_before", 64'(level_c), 64'd0);
        wait_cyc(k + LAT);
        check("al_level_after", 64'(level_c), 64'd1);
        wait_cyc(k + 15);
        btn_c[0] = 1'b1;
        wait_cyc(k + 30);

        // Clean press on ch0, held 40 cycles; last repeat coincides with release edge
        k = cyc;
        btn_a[0] = 1'b1;
        expect_train(0, 2'b01, k + LAT, k + 50, 5);
        expect_train(1, 2'b01, k + LAT, k + 50, 0);
        wait_cyc(k + LAT - 1);
        check("s1_level_before", 64'(level_a), 64'd0);
        wait_cyc(k + LAT);
        check("s1_level_a", 64'(level_a), 64'd1);
        check("s1_level_b", 64'(level_b), 64'd1);
        wait_cyc(k + 40);
        btn_a[0] = 1'b0;
        wait_cyc(k + 49);
        check("s3_level_held", 64'(level_a), 64'd1);
        wait_cyc(k + 50);
        check("s3_level_rel", 64'(level_a), 64'd0);
        wait_cyc(k + 60);

        // Glitches: 4-cycle bursts and a 7-cycle pulse are rejected
        for (int i = 0; i < 3; i++) begin
            btn_a[0] = 1'b1;
            tick(4);
            btn_a[0] = 1'b0;
            tick(4);
        end
        btn_a[0] = 1'b1;
        tick(7);
        btn_a[0] = 1'b0;
        tick(12);
        check("glitch_level", 64'(level_a), 64'd0);

        // An 8-cycle pulse is just long enough to be accepted
        k = cyc;
        btn_a[0] = 1'b1;
        expect_train(0, 2'b01, k + LAT, k + 18, 5);
        expect_train(1, 2'b01, k + LAT, k + 18, 0);
        wait_cyc(k + 8);
        btn_a[0] = 1'b0;
        wait_cyc(k + 30);

        // Hold and repeat on ch1
        k = cyc;
        btn_a[1] = 1'b1;
        expect_train(0, 2'b10, k + LAT, k + 48, 5);
        expect_train(1, 2'b10, k + LAT, k + 48, 0);
        wait_cyc(k + 38);
        btn_a[1] = 1'b0;
        wait_cyc(k + 60);

        // Simultaneous press, reset mid-hold, re-press after reset
        k = cyc;
        btn_a = 2'b11;
        push(0, k + LAT, 2'b11, 2'b00, 2'b00);
        push(1, k + LAT, 2'b11, 2'b00, 2'b00);
        wait_cyc(k + LAT);
        check("s5_level_both", 64'(level_a), 64'd3);
        wait_cyc(k + 21);
        rst = 1'b1;
        wait_cyc(k + 22);
        check("s5_rst_level", 64'(level_a), 64'd0);
        check("s5_rst_pulses", 64'({press_a, rel_a, hold_a, press_b, rel_b, hold_b}), 64'd0);
        rst = 1'b0;
        p2 = k + 22 + LAT;
        expect_train(0, 2'b11, p2, p2 + 32, 5);
        expect_train(1, 2'b11, p2, p2 + 32, 0);
        wait_cyc(p2 - 1);
        check("s5_level_pre", 64'(level_a), 64'd0);
        wait_cyc(p2);
        check("s5_level_re", 64'(level_a), 64'd3);
        wait_cyc(p2 + 22);
        btn_a = 2'b00;
        wait_cyc(p2 + 45);
        check("s5_level_end", 64'(level_b), 64'd0);

        check("qa_left", 64'(qa.size()), 64'd0);
        check("qb_left", 64'(qb.size()), 64'd0);
        check("qc_left", 64'(qc.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
